// File: rtl/adc_if.sv
// ADC-side bus between the scope capture block (master) and the converter or its emulator (slave).
interface adc_if;
   logic       iADC_CLK;
   logic       iADC_nOE;
   logic [7:0] oADC_Data;
   logic       oADC_Data_En;
   logic       oSample_Strobe;

   modport master (output iADC_CLK, iADC_nOE,
                   input  oADC_Data, oADC_Data_En, oSample_Strobe);
   modport slave  (input  iADC_CLK, iADC_nOE,
                   output oADC_Data, oADC_Data_En, oSample_Strobe);
endinterface

// File: rtl/adc_emulator.sv
// Fabric stand-in for the 8-bit pipelined parallel ADC: pattern generator behind a
// programmable-latency pipeline, clocked by rising edges of the scope's ADC clock.
module adc_emulator #(
   parameter int PIPE_LAT  = 5,
   parameter int RAMP_STEP = 1,
   parameter int SQ_HALF   = 64
) (
   input  logic       iClk,
   input  logic       iRst_n,
   input  logic [1:0] iMode,
   input  logic [7:0] iLevel,
   adc_if.slave       adc
);
   localparam int             CW       = $clog2(SQ_HALF);
   localparam logic [CW-1:0]  CNT_LAST = CW'(SQ_HALF - 1);
   localparam logic [7:0]     STEP8    = 8'(RAMP_STEP);
   localparam logic [8:0]     STEP9    = 9'(RAMP_STEP);

   logic                           clk_s1_q, clk_s2_q, clk_prev_q;
   logic                           noe_s1_q, noe_s2_q;
   logic                           strobe_q;
   logic [PIPE_LAT-1:0][7:0]       pipe_q, pipe_d;
   logic [7:0]                     acc_q, acc_d;
   logic [CW-1:0]                  cnt_q, cnt_d;
   logic                           phase_q, phase_d;
   logic                           up_q, up_d;
   logic [7:0]                     g;
   logic                           edge_ev;

   assign edge_ev = clk_s2_q & ~clk_prev_q;

   // Current sample and the generator state it would advance to on this edge.
   always_comb begin
      g       = acc_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      up_d    = up_q;
      case (iMode)
         2'd0: acc_d = acc_q + STEP8;
         2'd1: begin
            g = {8{phase_q}};
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               phase_d = ~phase_q;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         2'd2: begin
            // 9-bit compares so the turn-around never wraps through 0 or 255
            if (up_q) begin
               if ({1'b0, acc_q} >= 9'd255 - STEP9) begin
                  acc_d = 8'hFF;
                  up_d  = 1'b0;
               end else begin
                  acc_d = acc_q + STEP8;
               end
            end else begin
               if ({1'b0, acc_q} <= STEP9) begin
                  acc_d = 8'h00;
                  up_d  = 1'b1;
               end else begin
                  acc_d = acc_q - STEP8;
               end
            end
         end
         default: g = iLevel;
      endcase
   end

   always_comb begin
      pipe_d = pipe_q;
      if (edge_ev) begin
         pipe_d[0] = g;
         for (int i = 1; i < PIPE_LAT; i++) pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         clk_s1_q   <= 1'b0;
         clk_s2_q   <= 1'b0;
         clk_prev_q <= 1'b0;
         noe_s1_q   <= 1'b1;
         noe_s2_q   <= 1'b1;
         strobe_q   <= 1'b0;
         pipe_q     <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         phase_q    <= 1'b0;
         up_q       <= 1'b1;
      end else begin
         clk_s1_q   <= adc.iADC_CLK;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         noe_s1_q   <= adc.iADC_nOE;
         noe_s2_q   <= noe_s1_q;
         strobe_q   <= edge_ev;
         pipe_q     <= pipe_d;
         if (edge_ev) begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            up_q    <= up_d;
         end
      end
   end

   assign adc.oADC_Data      = noe_s2_q ? 8'h00 : pipe_q[PIPE_LAT-1];
   assign adc.oADC_Data_En   = ~noe_s2_q;
   assign adc.oSample_Strobe = strobe_q;
endmodule

// File: doc/adc_emulator.md
Name: adc_emulator

Overview:
- Behavioural stand-in for the 8-bit pipelined parallel ADC, implemented in fabric. It is the driving end of the interface that the scope capture block receives.
- It consumes the ADC_CLK / ADC_nOE pair that the scope drives and returns 8-bit pattern data, with a programmable pipeline latency.
- Used for loopback bring-up of the capture and downsampling chain without the real converter, and as a known-value source for bench verification.

Parameters:
- PIPE_LAT, 5: ADC pipeline depth in ADC clock edges; legal range is 1 or more.
- RAMP_STEP, 1: increment per ADC edge for ramp and triangle modes; legal range 1..127.
- SQ_HALF, 64: ADC edges per half period in square mode; legal range 2 or more.

Ports:
- iClk, input, 1: system clock, 100 MHz.
- iRst_n, input, 1: asynchronous, active-low reset.
- iADC_CLK, input, 1: ADC sample clock from the scope. Asynchronous to the emulator; high and low phases each last at least 3 iClk periods.
- iADC_nOE, input, 1: ADC output-enable, active low. Asynchronous.
- iMode, input, 2: pattern select. 0 = ramp, 1 = square, 2 = triangle, 3 = constant.
- iLevel, input, 8: value output in constant mode.
- oADC_Data, output, 8: emulated ADC output bus.
- oADC_Data_En, output, 1: bus-driven indicator; equals the synchronised ~nOE.
- oSample_Strobe, output, 1: one-iClk pulse each time oADC_Data takes a new sample.

Behaviour:
- Reset (iRst_n low, asynchronous): the following all reset to 0:
  - synchronisers and edge register
  - all pipeline stages
  - generator accumulator and square counter
  - square phase (low)
  - oSample_Strobe
  - Triangle direction resets to up. nOE synchroniser resets to 1, so oADC_Data_En = 0 and oADC_Data = 0x00.
- Reset takes effect mid-sample: the pipeline is cleared and no partial update is allowed.
- iADC_CLK and iADC_nOE each pass through a 2-flop synchroniser. A third register holds the previous synchronised clock.
- Rising-edge event: sync2 = 1 and prev = 0. The state update happens on the 3rd rising iClk edge after the raw iADC_CLK rise.
- Falling edges of iADC_CLK are ignored.
- On each edge event, all of the following happen in the same iClk cycle:
  - The generator presents the current sample g.
  - pipe[0] <= g, and pipe[i] <= pipe[i-1] for i = 1..PIPE_LAT-1.
  - The generator state advances.
  - oSample_Strobe is high for the following iClk cycle only.
- Samples are numbered s0, s1, ... from the first edge after reset. s_k is visible on pipe[PIPE_LAT-1] after edge k+PIPE_LAT, counting edges from 1.
- The first PIPE_LAT-1 edges after reset present 0x00.
- oADC_Data = pipe[PIPE_LAT-1] when nOE_sync = 0; otherwise 0x00.
- oADC_Data_En = ~nOE_sync. It changes 2 iClk cycles after the iADC_nOE change, independent of ADC edges.
- The pipeline and generator keep running while nOE is high. Re-enabling shows current pipeline contents, with no stale hold.
- Ramp mode (iMode = 0):
  - g = acc; then acc <= acc + RAMP_STEP, modulo 256.
  - Wraps silently, e.g. 0xFF + 1 gives 0x00.
- Square mode (iMode = 1):
  - g = 0xFF if phase else 0x00.
  - cnt increments each edge. When cnt = SQ_HALF-1, cnt <= 0 and phase toggles.
- Triangle mode (iMode = 2):
  - g = acc.
  - Going up: if acc >= 255-RAMP_STEP, then acc <= 255 and dir <= down; else acc <= acc + RAMP_STEP.
  - Going down: if acc <= RAMP_STEP, then acc <= 0 and dir <= up; else acc <= acc - RAMP_STEP.
  - The 9-bit comparison must never wrap.
- Constant mode (iMode = 3): g = iLevel, sampled at the edge event. acc, cnt and dir hold.
- Mode change:
  - iMode is sampled only at edge events.
  - The new mode takes effect for the sample generated at the next edge.
  - The generator state is shared and not cleared. Ramp and triangle both use acc.
  - Switching to square does not clear cnt or phase.
- If an edge event and an nOE change coincide, both are applied in the same cycle with no priority conflict.

Test Plan:
1. Reset; ramp mode; nOE low; PIPE_LAT = 5, RAMP_STEP = 1; 300 ADC edges -> oADC_Data shows 0x00 after edges 1-4, 0x00 after edge 5, 0x01 after edge 6, ... reaches 0xFF, then wraps to 0x00. One oSample_Strobe per edge.
2. Square mode, SQ_HALF = 4 -> after pipeline fill, output is 0x00 ×4, 0xFF ×4, repeating. The first 0xFF is s4, visible after edge 9.
3. Triangle mode, RAMP_STEP = 100 -> sample sequence 0, 100, 200, 255, 155, 55, 0, 100.
4. Ramp running; raise iADC_nOE for 20 edges, then lower -> oADC_Data_En = 0 and data = 0x00 two iClk after the rise. After the fall, data resumes at the value the ramp has advanced to (continuous), not the frozen value.
5. Constant mode with iLevel = 0xA5, changed to 0x3C between edges -> 0xA5 samples, then 0x3C starting exactly PIPE_LAT edges after the change edge.
6. Assert iRst_n low midway through triangle mode, asynchronous to iClk -> all outputs 0 and oADC_Data_En = 0 immediately. After release, the sequence restarts from s0 = 0x00 with direction up.
